// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
package mux4_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Registered arbiter response as seen by the requesters and the mux.
    typedef struct packed {
        logic [N_REQ-1:0] gnt;
        logic [SEL_W-1:0] sel;
        logic             busy;
    } arb_rsp_t;

    function automatic logic [N_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arb_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface mux4_rr_arb_if;
    import mux4_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             busy;

    modport master (output req, input gnt, sel, busy);
    modport slave  (input req, output gnt, sel, busy);
endinterface

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first set req bit at ptr, ptr+1, ... mod 4.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [N_REQ-1:0][SEL_W-1:0] cand;
    logic [N_REQ-1:0]            hit;

    // Candidate k is the requester k slots after the pointer; SEL_W-bit add wraps mod 4.
    for (genvar k = 0; k < N_REQ; k++) begin : g_cand
        assign cand[k] = ptr + SEL_W'(k);
        assign hit[k]  = req[cand[k]];
    end

    // Lowest rotated slot with a hit wins; scanning downwards leaves the nearest one.
    always_comb begin
        found = |hit;
        idx   = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (hit[k]) idx = cand[k];
        end
    end

endmodule

// File: rtl/mux4_rr_arb.sv
// Round-robin arbiter driving the select of a shared 4:1 mux, with a bounded hold time.
// HOLD_MAX legal range is 1..255.
module mux4_rr_arb
    import mux4_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    mux4_rr_arb_if.slave  bus
);

    localparam int              CNT_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    arb_rsp_t         rsp_q, rsp_d;

    logic             found;
    logic [SEL_W-1:0] win;
    logic             hold;

    // The same pick serves both the idle pick and the release pick: in both
    // cases ptr already points one past the previous winner.
    rr_pick4 u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .found (found),
        .idx   (win)
    );

    // Owner keeps the mux while it still requests and has not used up its hold budget.
    assign hold = (state_q == ARB_GRANT) && bus.req[rsp_q.sel] && (cnt_q < CNT_LAST);

    // State, pointer, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
        end
    end

    // Next state: enter GRANT on any winner, fall back to IDLE when a release finds nobody.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (found) state_d = ARB_GRANT;
            ARB_GRANT: if (!hold && !found) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Next outputs: hold counts up, otherwise grant the pick back-to-back or go idle keeping sel.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        rsp_d = rsp_q;
        if (hold) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (found) begin
            rsp_d.gnt  = idx2onehot(win);
            rsp_d.sel  = win;
            rsp_d.busy = 1'b1;
            cnt_d      = '0;
            ptr_d      = win + SEL_W'(1);
        end else begin
            rsp_d.gnt  = '0;
            rsp_d.busy = 1'b0;
            cnt_d      = '0;
        end
    end

    assign bus.gnt  = rsp_q.gnt;
    assign bus.sel  = rsp_q.sel;
    assign bus.busy = rsp_q.busy;

endmodule

// File: tb/tb_mux4_rr_arb.sv
// Scoreboard bench for mux4_rr_arb: directed scenarios plus random request traffic.
module tb_mux4_rr_arb;

    localparam int HOLD = 8;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mux4_rr_arb_if bus ();

    mux4_rr_arb #(.HOLD_MAX(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // Reference model: who owns the mux, for how many cycles, and where priority starts.
    int m_owner;
    int m_sel;
    int m_ptr;
    int m_held;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_sel   = 0;
        m_ptr   = 0;
        m_held  = 0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.gnt  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e.sel  = 2'(m_sel);
        e.busy = (m_owner >= 0);
        return e;
    endfunction

    task automatic model_step(input logic [3:0] r);
        int w;
        if (m_owner >= 0 && r[m_owner] && m_held < HOLD) begin
            m_held++;
        end else begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_sel   = w;
                m_ptr   = (w + 1) % 4;
                m_held  = 1;
            end else begin
                m_owner = -1;
            end
        end
    endtask

    task automatic drive(input logic [3:0] r);
        @(negedge clk);
        bus.req = r;
        model_step(r);
        sb.push_back(model_out());
    endtask

    task automatic drive_n(input logic [3:0] r, input int n);
        for (int i = 0; i < n; i++) drive(r);
    endtask

    // Assert reset away from the clock edge, check the asynchronous clear, release on the next negedge.
    task automatic pulse_reset();
        @(negedge clk);
        rst     = 1'b1;
        bus.req = 4'b0000;
        #1;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.sel !== 2'b00 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got gnt=%b sel=%b busy=%b, want gnt=0000 sel=00 busy=0",
                     bus.gnt, bus.sel, bus.busy);
        end
        model_reset();
        sb.push_back(model_out());
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every rising edge that has a pending expectation is compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.gnt !== e.gnt || bus.sel !== e.sel || bus.busy !== e.busy) begin
                    errors++;
                    $display("FAIL grant_seq @%0t: got gnt=%b sel=%b busy=%b, want gnt=%b sel=%b busy=%b",
                             $time, bus.gnt, bus.sel, bus.busy, e.gnt, e.sel, e.busy);
                end
            end
        end
    end

    initial begin
        logic [3:0] cur;
        bus.req = 4'b0000;
        model_reset();

        // Idle after reset.
        pulse_reset();
        drive_n(4'b0000, 5);

        // Full contention: 0,1,2,3,0 each for HOLD cycles, back-to-back.
        drive_n(4'b1111, 5 * HOLD);
        drive_n(4'b0000, 2);

        // Single short request, then release: sel stays on the last owner.
        pulse_reset();
        drive_n(4'b0100, 3);
        drive_n(4'b0000, 3);

        // Owner 1 releases with ptr=2 while 0 and 3 request: 3 wins.
        pulse_reset();
        drive_n(4'b0010, 3);
        drive_n(4'b1001, 2);
        drive_n(4'b0000, 2);

        // Lone requester past expiry is re-granted without a gap.
        pulse_reset();
        drive_n(4'b0010, 20);
        drive_n(4'b0000, 1);

        // Reset in the middle of requester 2's grant; first grant afterwards goes to 0.
        pulse_reset();
        drive_n(4'b1111, 2 * HOLD + 3);
        pulse_reset();
        drive_n(4'b1111, 3);

        // Random traffic with sticky request levels and occasional resets.
        cur = 4'b0000;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset();
            if ($urandom_range(0, 3) == 0) cur = 4'($urandom_range(0, 15));
            drive(cur);
        end
        drive_n(4'b0000, 2);

        // Drain: every expectation must have been consumed by the monitor.
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
